// File: rtl/arb_4in_pkg.sv
// Purpose: shared types and constants for the 4-input burst-lock arbiter family.
// Latency: n/a (types, constants, pure helper function only).
// Backpressure: n/a.
package arb_4in_pkg;

  localparam int NREQS = 4;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  typedef logic [NREQS-1:0] onehot4_t;

  // Rotate a one-hot vector left by one position (MSB wraps to bit 0).
  function automatic onehot4_t rotl1(input onehot4_t v);
    return {v[NREQS-2:0], v[NREQS-1]};
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Purpose: round-robin pick; search starts at the prio bit and wraps upward.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; winner is zero when no request is present.
module arb_rr_pick
  import arb_4in_pkg::*;
(
  input  onehot4_t prio,
  input  onehot4_t reqs,
  output onehot4_t winner
);

  logic [1:0] start;
  logic [1:0] idx;
  logic       found;
  logic       start_found;

  // Locate the prio bit, then walk upward (mod 4) to the first request.
  always_comb begin
    start       = 2'd0;
    start_found = 1'b0;
    idx         = 2'd0;
    found       = 1'b0;
    winner      = '0;
    for (int i = 0; i < NREQS; i++) begin
      if (!start_found && prio[i]) begin
        start       = 2'(i);
        start_found = 1'b1;
      end
    end
    for (int k = 0; k < NREQS; k++) begin
      idx = start + 2'(k);
      if (!found && reqs[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_4in_burst_lock.sv
// Purpose: 4-way round-robin arbiter that locks the grant for a whole burst.
// Latency: grant is combinational in IDLE; lock/prio updates visible next cycle.
// Backpressure: res_rdy=0 holds all state and keeps the grant asserted.
// Optional feature macro: ARB_4IN_BURST_LOCK_SET_PRIORITY_EN (priority load port).
module arb_4in_burst_lock
  import arb_4in_pkg::*;
#(
  parameter int NBITS_LEN = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQS-1:0]           reqs,
  input  logic [NREQS*NBITS_LEN-1:0] req_lens,
  input  logic                       res_rdy,
  output logic [NREQS-1:0]           grants,
  output logic                       busy,
  output logic                       last_beat
`ifdef ARB_4IN_BURST_LOCK_SET_PRIORITY_EN
  ,
  input  logic                       set_priority_en,
  input  logic [NREQS-1:0]           set_priority
`endif
);

  arb_state_t           state_q, state_d;
  onehot4_t             prio_q, prio_d;
  onehot4_t             owner_q, owner_d;
  logic [NBITS_LEN-1:0] rem_q, rem_d;

  onehot4_t             winner;
  logic [NBITS_LEN-1:0] win_len;
  logic                 xfer;

  arb_rr_pick u_pick (
    .prio   (prio_q),
    .reqs   (reqs),
    .winner (winner)
  );

  // Burst length of the current round-robin winner.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < NREQS; i++) begin
      if (winner[i]) begin
        win_len = req_lens[i*NBITS_LEN +: NBITS_LEN];
      end
    end
  end

  // Next-state and output logic; reset forces outputs low in the same cycle.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    rem_d     = rem_q;
    grants    = '0;
    busy      = 1'b0;
    last_beat = 1'b0;
    xfer      = 1'b0;

    case (state_q)
      IDLE: begin
        grants    = winner;
        last_beat = (winner != '0) && (win_len == '0);
        xfer      = (winner != '0) && res_rdy;
        if (xfer) begin
          if (win_len == '0) begin
            prio_d = rotl1(winner);
          end else begin
            state_d = LOCK;
            owner_d = winner;
            rem_d   = win_len;
          end
        end
      end
      LOCK: begin
        // Owner keeps the grant even if its request drops mid-burst.
        grants    = owner_q;
        busy      = 1'b1;
        last_beat = (rem_q == NBITS_LEN'(1));
        xfer      = res_rdy;
        if (xfer) begin
          if (rem_q > NBITS_LEN'(1)) begin
            rem_d = rem_q - NBITS_LEN'(1);
          end else begin
            state_d = IDLE;
            prio_d  = rotl1(owner_q);
            owner_d = '0;
            rem_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef ARB_4IN_BURST_LOCK_SET_PRIORITY_EN
    // A loaded priority wins over any rotation this cycle; lock state is untouched.
    if (set_priority_en) begin
      prio_d = set_priority;
    end
`endif

    if (reset) begin
      grants    = '0;
      busy      = 1'b0;
      last_beat = 1'b0;
    end
  end

  // State registers with synchronous reset; a reset mid-burst discards it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 4'b0001;
      owner_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      rem_q   <= rem_d;
    end
  end

endmodule
